hja_debug_probe: RTL and testbench
==================================

# hja_debug_probe

Parametrised successor to the board LED debug selector. Takes a flat bus of `NCH` probe channels, each `W` bits wide, and selects one with `sw[15:8]`. The selected channel goes to the LEDs in one of four modes: live, freeze, sticky-OR, or change-trace. It sits beside the CPU top level, driven by the system clock, and exists for single-board bring-up when no logic analyser is available.

## Interface
- `NCH`, default 80: number of probe channels, 1..256.
- `W`, default 16: channel and LED width.
- `DEPTH`, default 16: trace ring depth. Must be a power of two, 2..16.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `sw` input 16: board switches.
  - `sw[15:8]`: channel select `sel`.
  - `sw[7:6]`: mode.
  - `sw[3:0]`: trace index `idx`.
  - Other bits are ignored.
- `probe_bus` input NCH*W: channel k occupies bits `[k*W +: W]`.
- `led_data` output W: registered display value.
- `trace_count` output 5: number of valid trace entries, 0..DEPTH.
- `armed` output 1: one-cycle pulse on each arm event.

## Operation
- **Channel value `v`:**
  - `v = probe_bus[sel*W +: W]` when `sel < NCH`.
  - Otherwise `v = sw` zero-extended or truncated to W bits.
- **Modes:** 00 LIVE, 01 FREEZE, 10 STICKY, 11 TRACE.
- **Arm event:** in any non-reset cycle where `{mode, sel}` differs from the registered `{mode_q, sel_q}`.
  - `mode_q` and `sel_q` reset to 0.
  - In the arm cycle, `armed` = 1, and `mode_q`/`sel_q` are updated.
- **LIVE:** `led_data <= v`.
- **FREEZE:**
  - Arm cycle: `snap <= v`, `led_data <= v`.
  - Otherwise: `led_data <= snap`.
- **STICKY:**
  - Arm cycle: `acc <= v`, `led_data <= v`.
  - Otherwise: `acc <= acc | v`, `led_data <= acc | v`.
- **TRACE, arm cycle:**
  - `buf[0] <= v`, `wr_ptr <= 1`, `count <= 1`, `prev <= v`.
- **TRACE, non-arm cycle with `v != prev`:**
  - `buf[wr_ptr] <= v`, `wr_ptr <= (wr_ptr+1) mod DEPTH`, `prev <= v`.
  - `count <= min(count+1, DEPTH)`: saturates, oldest entry is overwritten.
- **TRACE, non-arm cycle with `v == prev`:** no write.
- **TRACE display:**
  - Computed from pre-edge register state.
  - `led_data <= (idx < count) ? buf[(wr_ptr-1-idx) mod DEPTH] : 0`.
  - `idx` = 0 is the newest entry.
  - On the arm cycle, `led_data <= 0` (count is still 0 pre-edge).
- **`trace_count`:** equals `count`.
  - Cleared to 0 on any arm into a non-TRACE mode.
  - Holds its value otherwise while not in TRACE.
- **Reset:** `led_data`, `trace_count`, `armed`, `wr_ptr`, `snap`, `acc`, `prev`, `mode_q`, `sel_q` are all 0. Buffer contents are don't-care.

## Timing
- **LIVE latency:** `led_data` reflects `v` one cycle after it is sampled.
- **Arm detection:** combinational from `sw` against the registered values. The arm takes effect on the same edge.
- **Simultaneous arm and change:** arm wins; the buffer restarts with the current `v`.
- **Reset mid-trace:** all pointers clear on that edge. The first non-reset cycle is an arm only if `{mode, sel}` ≠ 0. With `sw` = 0, that cycle is LIVE on channel 0.
- **Wrap-around:**
  - After DEPTH+1 changes, the oldest surviving entry is `idx = DEPTH-1`.
  - `count` stays at DEPTH.
- **Switch inputs:** `sw` is asynchronous. It must pass through a 2-flop synchroniser inside the block before use; the arm rule then applies to the synchronised value. This adds 2 cycles of switch-to-effect latency.

## Structure
- **Shared package `hja_dbg_pkg`:**
  - Mode constants `DBG_LIVE`, `DBG_FREEZE`, `DBG_STICKY`, `DBG_TRACE`.
  - Select field position (bits 15:8).
  - Mode field position (bits 7:6).
  - Index field position (bits 3:0).
- **Sub-module `hja_trace_ring`** (parameters W, DEPTH):
  - Holds `buf`, `wr_ptr`, `count`, `prev`.
  - Inputs: `clear`, `v`, `en`.
  - Provides the read-by-age port.
- **Top level:** channel mux, synchroniser, arm detection, freeze/sticky registers and the output register.

## Test plan
- **LIVE:** NCH=4, ch2 = 0x1234, `sw` = 0x0200 → after sync plus 1 cycle, `led_data` = 0x1234. Change ch2 to 0xBEEF → `led_data` follows 1 cycle later.
- **FREEZE:** ch1 = 0x00AA, set `sw` = 0x0140 → `armed` pulses once, `led_data` = 0x00AA. Ch1 → 0x5555 → `led_data` stays 0x00AA. Change `sel` to 0 → re-arm and new snapshot.
- **STICKY:** ch0 sequence 0x0001, 0x0010, 0x0000, 0x8000 in mode 10 → `led_data` ends at 0x8011. Re-entering mode 10 clears it to the current value.
- **TRACE:**
  - Setup: DEPTH=4, ch3 sequence 1,1,2,3,3,4,5,6.
  - Response: `trace_count` saturates at 4.
  - `idx` 0..3 show 6,5,4,3.
  - `idx` = 5 shows 0.
- **Out-of-range select and reset:**
  - `sel` = 0xFF with NCH=4 and mode 00 → `led_data` = `sw` = 0xFF00.
  - Assert `rst` mid-trace → `led_data` = 0, `trace_count` = 0 on the next edge.

Source files
------------

// File: rtl/hja_dbg_pkg.sv
// Shared definitions for the LED debug probe: display modes and switch field positions.
package hja_dbg_pkg;

    typedef enum logic [1:0] {
        DBG_LIVE   = 2'b00,
        DBG_FREEZE = 2'b01,
        DBG_STICKY = 2'b10,
        DBG_TRACE  = 2'b11
    } dbg_mode_e;

    localparam int SEL_MSB  = 15;
    localparam int SEL_LSB  = 8;
    localparam int MODE_MSB = 7;
    localparam int MODE_LSB = 6;
    localparam int IDX_MSB  = 3;
    localparam int IDX_LSB  = 0;
    localparam int IDX_W    = IDX_MSB - IDX_LSB + 1;

endpackage

// File: rtl/hja_trace_ring.sv
// Change-trace ring: records each distinct value of v while enabled, readable by age (idx 0 = newest).
module hja_trace_ring
    import hja_dbg_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [W-1:0]     v,
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     rd_data,
    output logic [4:0]       count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  buf_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_addr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  prev;
    logic          write;

    // A clear while enabled restarts the ring with the current value at slot 0.
    assign write   = en && (clear || (v != prev));
    assign wr_addr = clear ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst && write) begin
            buf_mem[wr_addr] <= v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            prev   <= '0;
        end else if (clear) begin
            if (en) begin
                wr_ptr <= PW'(1);
                count  <= 5'd1;
                prev   <= v;
            end else begin
                count  <= '0;
            end
        end else if (en && (v != prev)) begin
            wr_ptr <= wr_ptr + PW'(1);
            prev   <= v;
            if (count != 5'(DEPTH)) begin
                count <= count + 5'd1;
            end
        end
    end

    // Pointer arithmetic wraps naturally modulo DEPTH (power of two).
    assign rd_ptr  = wr_ptr - PW'(1) - idx[PW-1:0];
    assign rd_data = ({1'b0, idx} < count) ? buf_mem[rd_ptr] : '0;

endmodule

// File: rtl/hja_debug_probe.sv
// Board LED debug selector: picks one probe channel by switches and shows it live, frozen, OR-accumulated or as a change trace.
module hja_debug_probe
    import hja_dbg_pkg::*;
#(
    parameter int NCH   = 80,
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sw,
    input  logic [NCH*W-1:0] probe_bus,
    output logic [W-1:0]     led_data,
    output logic [4:0]       trace_count,
    output logic             armed
);

    logic [15:0]      sw_meta;
    logic [15:0]      sw_sync;
    logic [7:0]       sel;
    dbg_mode_e        mode;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     v;
    logic             arm;
    logic [7:0]       sel_q;
    dbg_mode_e        mode_q;
    logic [W-1:0]     snap;
    logic [W-1:0]     acc;
    logic [W-1:0]     trace_rd;
    logic             unused_sw;

    // Switches are asynchronous to clk; everything downstream sees only sw_sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign sel       = sw_sync[SEL_MSB:SEL_LSB];
    assign mode      = dbg_mode_e'(sw_sync[MODE_MSB:MODE_LSB]);
    assign idx       = sw_sync[IDX_MSB:IDX_LSB];
    assign unused_sw = ^sw_sync[5:4];

    // Selects past the last channel show the switch word itself.
    always_comb begin
        v = W'(sw_sync);
        if ({1'b0, sel} < 9'(NCH)) begin
            v = probe_bus[int'(sel)*W +: W];
        end
    end

    assign arm = (mode != mode_q) || (sel != sel_q);

    hja_trace_ring #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm),
        .en      (mode == DBG_TRACE),
        .v       (v),
        .idx     (idx),
        .rd_data (trace_rd),
        .count   (trace_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            led_data <= '0;
            armed    <= 1'b0;
            mode_q   <= DBG_LIVE;
            sel_q    <= '0;
            snap     <= '0;
            acc      <= '0;
        end else begin
            armed  <= arm;
            mode_q <= mode;
            sel_q  <= sel;
            case (mode)
                DBG_LIVE: begin
                    led_data <= v;
                end
                DBG_FREEZE: begin
                    if (arm) begin
                        snap     <= v;
                        led_data <= v;
                    end else begin
                        led_data <= snap;
                    end
                end
                DBG_STICKY: begin
                    if (arm) begin
                        acc      <= v;
                        led_data <= v;
                    end else begin
                        acc      <= acc | v;
                        led_data <= acc | v;
                    end
                end
                DBG_TRACE: begin
                    // The ring is being restarted on an arm edge, so nothing valid to show yet.
                    led_data <= arm ? '0 : trace_rd;
                end
                default: begin
                    led_data <= v;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hja_debug_probe.sv
// Directed bench for hja_debug_probe with a queued scoreboard checked at the falling edge.
module tb_hja_debug_probe;

    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    localparam int K_LED   = 0;
    localparam int K_COUNT = 1;
    localparam int K_ARMED = 2;

    logic             clk;
    logic             rst;
    logic [15:0]      sw;
    logic [NCH*W-1:0] probe_bus;
    logic [W-1:0]     led_data;
    logic [4:0]       trace_count;
    logic             armed;

    logic [W-1:0] exp_q [$];
    int           kind_q [$];
    string        name_q [$];

    int n_vec;
    int n_err;

    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    int           cur_kind;
    string        cur_name;

    hja_debug_probe #(
        .NCH   (NCH),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .probe_bus   (probe_bus),
        .led_data    (led_data),
        .trace_count (trace_count),
        .armed       (armed)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] val);
        probe_bus[k*W +: W] = val;
    endtask

    task automatic expect_out(input int kind, input logic [W-1:0] val, input string name);
        exp_q.push_back(val);
        kind_q.push_back(kind);
        name_q.push_back(name);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            cur_kind = kind_q.pop_front();
            cur_name = name_q.pop_front();
            case (cur_kind)
                K_LED:   act_v = led_data;
                K_COUNT: act_v = W'(trace_count);
                default: act_v = W'(armed);
            endcase
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", cur_name, act_v, exp_v);
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        sw        = 16'h0000;
        probe_bus = '0;
        step(2);
        expect_out(K_LED,   16'h0000, "reset_led");
        expect_out(K_COUNT, 16'h0000, "reset_count");
        expect_out(K_ARMED, 16'h0000, "reset_armed");

        // LIVE on channel 2
        rst = 1'b0;
        set_ch(2, 16'h1234);
        sw = 16'h0200;
        step(3);
        expect_out(K_LED,   16'h1234, "live_first");
        expect_out(K_ARMED, 16'h0001, "live_arm");
        step(1);
        expect_out(K_ARMED, 16'h0000, "live_arm_pulse_end");
        set_ch(2, 16'hBEEF);
        step(1);
        expect_out(K_LED,   16'hBEEF, "live_follow");

        // FREEZE on channel 1, then re-arm on channel 0
        set_ch(1, 16'h00AA);
        sw = 16'h0140;
        step(3);
        expect_out(K_ARMED, 16'h0001, "freeze_arm");
        expect_out(K_LED,   16'h00AA, "freeze_snap");
        step(1);
        expect_out(K_ARMED, 16'h0000, "freeze_arm_once");
        set_ch(1, 16'h5555);
        step(2);
        expect_out(K_LED,   16'h00AA, "freeze_hold");
        set_ch(0, 16'h0777);
        sw = 16'h0040;
        step(3);
        expect_out(K_ARMED, 16'h0001, "freeze_rearm");
        expect_out(K_LED,   16'h0777, "freeze_new_snap");
        set_ch(0, 16'h0888);
        step(1);
        expect_out(K_LED,   16'h0777, "freeze_new_hold");
        expect_out(K_COUNT, 16'h0000, "freeze_count_zero");

        // STICKY on channel 0
        set_ch(0, 16'h0001);
        sw = 16'h0080;
        step(3);
        expect_out(K_LED, 16'h0001, "sticky_arm");
        set_ch(0, 16'h0010);
        step(1);
        expect_out(K_LED, 16'h0011, "sticky_or1");
        set_ch(0, 16'h0000);
        step(1);
        expect_out(K_LED, 16'h0011, "sticky_or2");
        set_ch(0, 16'h8000);
        step(1);
        expect_out(K_LED, 16'h8011, "sticky_or3");
        sw = 16'h0000;
        step(3);
        expect_out(K_LED, 16'h8000, "sticky_to_live");
        set_ch(0, 16'h0002);
        sw = 16'h0080;
        step(3);
        expect_out(K_LED,   16'h0002, "sticky_reenter");
        expect_out(K_ARMED, 16'h0001, "sticky_reenter_arm");
        set_ch(0, 16'h0004);
        step(1);
        expect_out(K_LED, 16'h0006, "sticky_after_reenter");

        // TRACE on channel 3: 1,1,2,3,3,4,5,6
        set_ch(3, 16'h0001);
        sw = 16'h03C0;
        step(3);
        expect_out(K_LED,   16'h0000, "trace_arm_led");
        expect_out(K_COUNT, 16'h0001, "trace_arm_count");
        expect_out(K_ARMED, 16'h0001, "trace_arm");
        set_ch(3, 16'h0001); step(1);
        expect_out(K_COUNT, 16'h0001, "trace_repeat_nowrite");
        set_ch(3, 16'h0002); step(1);
        set_ch(3, 16'h0003); step(1);
        set_ch(3, 16'h0003); step(1);
        expect_out(K_COUNT, 16'h0003, "trace_count3");
        set_ch(3, 16'h0004); step(1);
        expect_out(K_COUNT, 16'h0004, "trace_count4");
        set_ch(3, 16'h0005); step(1);
        set_ch(3, 16'h0006); step(1);
        expect_out(K_COUNT, 16'h0004, "trace_saturate");
        expect_out(K_LED,   16'h0005, "trace_pre_edge_view");
        step(1);
        expect_out(K_LED,   16'h0006, "trace_idx0");
        sw = 16'h03C1; step(3);
        expect_out(K_LED,   16'h0005, "trace_idx1");
        sw = 16'h03C2; step(3);
        expect_out(K_LED,   16'h0004, "trace_idx2");
        sw = 16'h03C3; step(3);
        expect_out(K_LED,   16'h0003, "trace_idx3_oldest");
        sw = 16'h03C4; step(3);
        expect_out(K_LED,   16'h0000, "trace_idx4_empty");
        sw = 16'h03C5; step(3);
        expect_out(K_LED,   16'h0000, "trace_idx5_empty");
        expect_out(K_COUNT, 16'h0004, "trace_count_held");

        // reset mid-trace
        rst = 1'b1;
        step(1);
        expect_out(K_LED,   16'h0000, "midrst_led");
        expect_out(K_COUNT, 16'h0000, "midrst_count");
        expect_out(K_ARMED, 16'h0000, "midrst_armed");

        // out-of-range select shows the switch word
        rst = 1'b0;
        sw  = 16'hFF00;
        step(3);
        expect_out(K_LED,   16'hFF00, "oob_sel_led");
        expect_out(K_ARMED, 16'h0001, "oob_sel_arm");

        // arm into a non-trace mode clears the count
        set_ch(3, 16'h0007);
        sw = 16'h03C0;
        step(3);
        expect_out(K_COUNT, 16'h0001, "retrace_count");
        sw = 16'h0300;
        step(3);
        expect_out(K_COUNT, 16'h0000, "leave_trace_clear");
        expect_out(K_LED,   16'h0007, "leave_trace_live");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
